// File: rtl/ttt_pkg.sv
// Purpose: shared types and constants for the tic-tac-toe controller and display logic.
// Latency: none (declarations only).
// Backpressure: none.
package ttt_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P0    = 2'b01,
      P1    = 2'b10,
      BAD   = 2'b11
   } cell_t;

   typedef cell_t [8:0] board_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_MOVE,
      PLACE,
      WAIT_ACK,
      CHECK,
      GAME_OVER
   } state_t;

   localparam int NUM_CELLS = 9;

endpackage

// File: rtl/ttt_line_check.sv
// Purpose: combinational board evaluation (winner code, full, illegal code, lowest empty cell).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows the board image continuously.
module ttt_line_check
   import ttt_pkg::*;
(
   input  board_t     board,
   output logic [1:0] win_code,
   output logic       full,
   output logic       illegal,
   output logic [3:0] first_empty
);

   // Three equal player codes on a line give that code; empty or illegal codes never win.
   function automatic logic [1:0] line3(input cell_t a, input cell_t b, input cell_t c);
      if (a == b && b == c && a != EMPTY && a != BAD) begin
         return a;
      end
      return 2'b00;
   endfunction

   logic [1:0] lw [8];

   // Evaluate rows, columns and diagonals; lowest-numbered winning line takes priority.
   always_comb begin
      lw[0] = line3(board[0], board[1], board[2]);
      lw[1] = line3(board[3], board[4], board[5]);
      lw[2] = line3(board[6], board[7], board[8]);
      lw[3] = line3(board[0], board[3], board[6]);
      lw[4] = line3(board[1], board[4], board[7]);
      lw[5] = line3(board[2], board[5], board[8]);
      lw[6] = line3(board[0], board[4], board[8]);
      lw[7] = line3(board[2], board[4], board[6]);
      win_code = 2'b00;
      for (int l = 0; l < 8; l++) begin
         if (win_code == 2'b00) begin
            win_code = lw[l];
         end
      end
   end

   // Scan downwards so the last empty cell seen is the lowest index; 4'hF means none empty.
   always_comb begin
      full        = 1'b1;
      illegal     = 1'b0;
      first_empty = 4'hF;
      for (int i = NUM_CELLS - 1; i >= 0; i--) begin
         if (board[i] == EMPTY) begin
            full        = 1'b0;
            first_empty = 4'(i);
         end
         if (board[i] == BAD) begin
            illegal = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Purpose: tic-tac-toe turn sequencer: validates moves, drives board place/ack, judges, times turns.
// Latency: accepted move -> colocar 1 cycle; full move = PLACE + WAIT_ACK (>=1) + CHECK.
// Backpressure: waits up to ACK_CYCLES for colocado (fault on expiry); moves only taken in WAIT_MOVE.
module ttt_game_ctrl
   import ttt_pkg::*;
#(
   parameter logic [31:0] TURN_CYCLES = 32'd50_000_000,
   parameter logic [7:0]  ACK_CYCLES  = 8'd16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       move_valid,
   input  logic [3:0] move_pos,
   input  board_t     board,
   input  logic       colocado,
   output logic       colocar,
   output logic [3:0] pos,
   output logic       jugador,
   output logic       move_reject,
   output logic       timeout,
   output logic       game_over,
   output logic [1:0] winner,
   output logic       fault
);

   state_t      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [7:0]  ack_q, ack_d;
   logic [3:0]  pos_d;
   logic        jug_d;
   logic [1:0]  win_d;
   logic        fault_d;
   logic [1:0]  win_code;
   logic        full, illegal;
   logic [3:0]  first_empty;
   logic        cell_ok;

   ttt_line_check u_line (
      .board       (board),
      .win_code    (win_code),
      .full        (full),
      .illegal     (illegal),
      .first_empty (first_empty)
   );

   // A request is acceptable only for an on-board cell that is currently empty.
   always_comb begin
      cell_ok = 1'b0;
      if (move_pos < 4'(NUM_CELLS)) begin
         cell_ok = (board[move_pos] == EMPTY);
      end
   end

   // Next-state and datapath decisions; pulses are Mealy outputs of WAIT_MOVE.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      ack_d       = ack_q;
      pos_d       = pos;
      jug_d       = jugador;
      win_d       = winner;
      fault_d     = fault;
      move_reject = 1'b0;
      timeout     = 1'b0;
      case (state_q)
         IDLE, GAME_OVER: begin
            if (start) begin
               state_d = WAIT_MOVE;
               timer_d = TURN_CYCLES - 32'd1;
               jug_d   = 1'b0;
               win_d   = 2'b00;
               fault_d = 1'b0;
            end
         end
         WAIT_MOVE: begin
            timer_d = (timer_q != 32'd0) ? timer_q - 32'd1 : 32'd0;
            if (move_valid && cell_ok) begin
               pos_d   = move_pos;
               state_d = PLACE;
            end else begin
               move_reject = move_valid;
               if (timer_q == 32'd0) begin
                  timeout = 1'b1;
                  if (!full) begin
                     pos_d   = first_empty;
                     state_d = PLACE;
                  end else begin
                     state_d = CHECK;
                  end
               end
            end
         end
         PLACE: begin
            ack_d   = 8'd1;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            ack_d = ack_q + 8'd1;
            if (colocado) begin
               state_d = CHECK;
            end else if (ack_q >= (ACK_CYCLES - 8'd1)) begin
               fault_d = 1'b1;
               win_d   = 2'b00;
               state_d = GAME_OVER;
            end
         end
         CHECK: begin
            if (illegal) begin
               fault_d = 1'b1;
               win_d   = 2'b00;
               state_d = GAME_OVER;
            end else if (win_code != 2'b00) begin
               win_d   = win_code;
               state_d = GAME_OVER;
            end else if (full) begin
               win_d   = 2'b00;
               state_d = GAME_OVER;
            end else begin
               jug_d   = ~jugador;
               timer_d = TURN_CYCLES - 32'd1;
               state_d = WAIT_MOVE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; synchronous active-low reset wins over every event.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         ack_q   <= '0;
         pos     <= '0;
         jugador <= 1'b0;
         winner  <= 2'b00;
         fault   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         ack_q   <= ack_d;
         pos     <= pos_d;
         jugador <= jug_d;
         winner  <= win_d;
         fault   <= fault_d;
      end
   end

   assign colocar   = (state_q == PLACE);
   assign game_over = (state_q == GAME_OVER);

endmodule

// File: tb/tb_ttt_game_ctrl.sv
module tb_ttt_game_ctrl;
   import ttt_pkg::*;

   localparam int TURN = 10;
   localparam int ACKC = 4;

   logic       clk = 1'b0;
   logic       rst, start, move_valid, colocado;
   logic [3:0] move_pos;
   board_t     board_m;
   logic       colocar, jugador, move_reject, timeout, game_over, fault;
   logic [3:0] pos;
   logic [1:0] winner;

   int checks = 0;
   int errors = 0;

   bit         jug_m, over_m, fault_m;
   logic [1:0] win_m;
   int         rejq[$];
   int         lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   ttt_game_ctrl #(.TURN_CYCLES(32'd10), .ACK_CYCLES(8'd4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .move_valid  (move_valid),
      .move_pos    (move_pos),
      .board       (board_m),
      .colocado    (colocado),
      .colocar     (colocar),
      .pos         (pos),
      .jugador     (jugador),
      .move_reject (move_reject),
      .timeout     (timeout),
      .game_over   (game_over),
      .winner      (winner),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_board();
      for (int i = 0; i < NUM_CELLS; i++) board_m[i] = EMPTY;
   endtask

   function automatic int lowest_empty();
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (board_m[i] == EMPTY) return i;
      end
      return -1;
   endfunction

   // Game rules on the model board: illegal code, then any line of three, then full board.
   task automatic judge(output bit over, output logic [1:0] win, output bit flt);
      int nfill;
      over = 0; win = 2'b00; flt = 0; nfill = 0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (board_m[i] == BAD) flt = 1;
         if (board_m[i] != EMPTY) nfill++;
      end
      if (flt) begin
         over = 1;
         return;
      end
      for (int l = 0; l < 8; l++) begin
         if (!over && board_m[lines[l][0]] != EMPTY &&
             board_m[lines[l][0]] == board_m[lines[l][1]] &&
             board_m[lines[l][1]] == board_m[lines[l][2]]) begin
            win  = board_m[lines[l][0]];
            over = 1;
         end
      end
      if (!over && nfill == NUM_CELLS) over = 1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_colocar"}, colocar, 0);
      chk({tag, "_pos"}, pos, 0);
      chk({tag, "_jugador"}, jugador, 0);
      chk({tag, "_reject"}, move_reject, 0);
      chk({tag, "_timeout"}, timeout, 0);
      chk({tag, "_game_over"}, game_over, 0);
      chk({tag, "_winner"}, winner, 0);
      chk({tag, "_fault"}, fault, 0);
   endtask

   // Start pulse from IDLE or GAME_OVER; the bench, acting as the board, clears its cells.
   task automatic start_game();
      clear_board();
      start = 1;
      step();
      start = 0;
      jug_m = 0; over_m = 0; fault_m = 0; win_m = 2'b00;
      #1;
      chk("start_game_over", game_over, 0);
      chk("start_fault", fault, 0);
      chk("start_winner", winner, 0);
      chk("start_jugador", jugador, 0);
   endtask

   // One turn from the first WAIT_MOVE cycle: queued rejects, then a request or a timeout,
   // then the board acknowledge after ack_dly cycles and the judged outcome.
   task automatic do_move(input int req, input int ack_dly, input bit use_to, input bit bad);
      int placed;
      int k;
      bit o, f;
      logic [1:0] w;
      placed = -1;
      k = 1;
      while (placed < 0 && k <= TURN + 2) begin
         if (rejq.size() > 0) begin
            move_valid = 1;
            move_pos   = 4'(rejq.pop_front());
            #1;
            chk("reject_pulse", move_reject, 1);
            if (k == TURN) placed = lowest_empty();
         end else if (!use_to) begin
            move_valid = 1;
            move_pos   = 4'(req);
            #1;
            chk("accept_no_reject", move_reject, 0);
            placed = req;
         end else begin
            move_valid = 0;
            #1;
            chk("wait_no_reject", move_reject, 0);
            if (k == TURN) placed = lowest_empty();
         end
         chk("turn_timeout", timeout, (k == TURN && (use_to || rejq.size() >= 0) && placed >= 0 && (use_to || move_reject)) ? 1 : 0);
         chk("wait_colocar", colocar, 0);
         chk("wait_jugador", jugador, jug_m);
         step();
         move_valid = 0;
         k++;
      end
      #1;
      chk("place_colocar", colocar, 1);
      chk("place_pos", pos, placed);
      for (int d = 1; d < ack_dly; d++) begin
         step();
         chk("ack_wait_colocar", colocar, 0);
         chk("ack_wait_pos", pos, placed);
      end
      step();
      colocado = 1;
      if (placed >= 0) board_m[placed] = jug_m ? P1 : P0;
      if (bad) board_m[8] = BAD;
      #1;
      chk("ack_pos_held", pos, placed);
      step();
      colocado = 0;
      #1;
      chk("check_colocar", colocar, 0);
      chk("check_game_over", game_over, 0);
      judge(o, w, f);
      over_m = o; win_m = w; fault_m = f;
      if (!o) jug_m = ~jug_m;
      step();
      chk("result_game_over", game_over, over_m);
      chk("result_winner", winner, win_m);
      chk("result_fault", fault, fault_m);
      chk("result_jugador", jugador, jug_m);
   endtask

   initial begin
      int plan [9];
      int q[$];
      int req, nrej;
      bit use_to;

      rst = 0; start = 0; move_valid = 0; colocado = 0; move_pos = 4'd0;
      clear_board();
      step();
      step();
      check_all_zero("reset");
      rst = 1;

      // Win on the top row by player0; rejects for an occupied and an off-board cell first.
      start_game();
      do_move(0, 2, 0, 0);
      do_move(3, 2, 0, 0);
      do_move(1, 2, 0, 0);
      do_move(4, 2, 0, 0);
      rejq.push_back(4);
      rejq.push_back(12);
      do_move(2, 2, 0, 0);
      chk("row_win_over", game_over, 1);
      chk("row_win_code", winner, 2'b01);

      // Draw fill; the third move is placed by timeout into cell 2.
      plan = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      start_game();
      for (int m = 0; m < 9; m++) begin
         do_move(plan[m], 2, (m == 2), 0);
      end
      chk("draw_over", game_over, 1);
      chk("draw_code", winner, 2'b00);

      // Missing acknowledge: fault and game over four cycles after colocar.
      start_game();
      move_valid = 1; move_pos = 4'd0;
      step();
      move_valid = 0;
      #1;
      chk("noack_colocar", colocar, 1);
      for (int d = 1; d < ACKC; d++) begin
         step();
         chk("noack_wait_over", game_over, 0);
         chk("noack_wait_fault", fault, 0);
      end
      step();
      chk("noack_fault", fault, 1);
      chk("noack_over", game_over, 1);
      chk("noack_winner", winner, 0);
      start_game();

      // Reset in the middle of the handshake, then a late acknowledge.
      move_valid = 1; move_pos = 4'd5;
      step();
      move_valid = 0;
      #1;
      chk("mid_colocar", colocar, 1);
      step();
      rst = 0;
      step();
      check_all_zero("mid_reset");
      rst = 1;
      colocado = 1;
      step();
      colocado = 0;
      for (int i = 0; i < TURN + 2; i++) begin
         #1;
         chk("idle_colocar", colocar, 0);
         chk("idle_timeout", timeout, 0);
         chk("idle_over", game_over, 0);
         step();
      end

      // Illegal cell code seen on the board after a commit.
      start_game();
      do_move(0, 1, 0, 1);
      chk("bad_cell_fault", fault, 1);

      // Randomized games with rejects, timeouts and varying ack latency.
      for (int g = 0; g < 25; g++) begin
         start_game();
         while (!over_m) begin
            nrej = $urandom_range(0, 2);
            for (int r = 0; r < nrej; r++) begin
               q.delete();
               for (int i = 0; i < NUM_CELLS; i++) if (board_m[i] != EMPTY) q.push_back(i);
               if (q.size() > 0 && $urandom_range(0, 1) == 1) rejq.push_back(q[$urandom_range(0, q.size() - 1)]);
               else rejq.push_back($urandom_range(9, 15));
            end
            q.delete();
            for (int i = 0; i < NUM_CELLS; i++) if (board_m[i] == EMPTY) q.push_back(i);
            req    = q[$urandom_range(0, q.size() - 1)];
            use_to = ($urandom_range(0, 3) == 0);
            do_move(req, $urandom_range(1, ACKC - 1), use_to, 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
